// File: rtl/vme_chan_regs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vme_chan_regs_pkg
// Description : Field offsets, limits and address-decode helpers shared by the
//               multi-channel VME control/status register bank.
// Revision    : 1.0 - initial release
// ============================================================================
package vme_chan_regs_pkg;

    // CTRL register fields
    localparam int EN_BIT     = 0;
    localparam int PULSE_BIT  = 1;
    localparam int VAL_LSB    = 2;

    // STAT register fields
    localparam int EVT_BIT    = 0;
    localparam int CNTCLR_BIT = 1;
    localparam int CNT_LSB    = 16;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    // Even word addresses select CTRL, odd ones STAT
    function automatic logic addr_is_ctrl(input logic [31:0] addr);
        return ~addr[0];
    endfunction

    // Two words per channel
    function automatic int unsigned addr_chan(input logic [31:0] addr);
        return {1'b0, addr[31:1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/vme_chan_regs_ch.sv
`default_nettype none
// ============================================================================
// Module      : vme_chan_regs_ch
// Description : One channel of the register bank: CTRL (enable, pulse, value)
//               and STAT (sticky event flag, saturating event counter).
// Revision    : 1.0 - initial release
// ============================================================================
module vme_chan_regs_ch
    import vme_chan_regs_pkg::*;
#(
    parameter int VAL_W = 10
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             ctrl_wr_i,
    input  logic             stat_wr_i,
    input  logic [31:0]      wr_data_i,
    input  logic             evt_i,
    output logic             en_o,
    output logic [VAL_W-1:0] val_o,
    output logic             pulse_o,
    output logic [31:0]      ctrl_rd_o,
    output logic [31:0]      stat_rd_o
);

    logic             en_q,    en_d;
    logic [VAL_W-1:0] val_q,   val_d;
    logic             pulse_q, pulse_d;
    logic             flag_q,  flag_d;
    logic [15:0]      cnt_q,   cnt_d;

    // Data bits above the value field carry no meaning for this channel
    logic unused_wdata;
    assign unused_wdata = &{1'b0, wr_data_i[31:VAL_W+2]};

    // Next-state: register writes, then event set/increment which take priority
    always_comb begin
        en_d    = en_q;
        val_d   = val_q;
        pulse_d = 1'b0;
        flag_d  = flag_q;
        cnt_d   = cnt_q;
        if (ctrl_wr_i) begin
            en_d    = wr_data_i[EN_BIT];
            val_d   = wr_data_i[VAL_LSB +: VAL_W];
            pulse_d = wr_data_i[PULSE_BIT];
        end
        if (stat_wr_i && wr_data_i[EVT_BIT]) begin
            flag_d = 1'b0;
        end
        if (evt_i) begin
            flag_d = 1'b1;
        end
        if (stat_wr_i && wr_data_i[CNTCLR_BIT]) begin
            cnt_d = '0;
        end
        if (evt_i && (cnt_d != CNT_MAX)) begin
            cnt_d = cnt_d + 16'd1;
        end
    end

    // Channel state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_q    <= 1'b0;
            val_q   <= '0;
            pulse_q <= 1'b0;
            flag_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            en_q    <= en_d;
            val_q   <= val_d;
            pulse_q <= pulse_d;
            flag_q  <= flag_d;
            cnt_q   <= cnt_d;
        end
    end

    // Read-back images; undriven bits are zero
    always_comb begin
        ctrl_rd_o                     = '0;
        ctrl_rd_o[EN_BIT]             = en_q;
        ctrl_rd_o[VAL_LSB +: VAL_W]   = val_q;
        stat_rd_o                     = '0;
        stat_rd_o[EVT_BIT]            = flag_q;
        stat_rd_o[CNT_LSB +: 16]      = cnt_q;
    end

    assign en_o    = en_q;
    assign val_o   = val_q;
    assign pulse_o = pulse_q;

endmodule
`default_nettype wire

// File: rtl/vme_chan_regs.sv
`default_nettype none
// ============================================================================
// Module      : vme_chan_regs
// Description : NCH-channel control/status register bank on the VME memory
//               bus, with address decode, error response and optional
//               write-in / read-out register stages.
// Revision    : 1.0 - initial release
// ============================================================================
module vme_chan_regs
    import vme_chan_regs_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int VAL_W   = 10,
    parameter int PIPE_WR = 1,
    parameter int PIPE_RD = 1,
    parameter int ADDR_W  = 5
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic [ADDR_W-1:0]    VMEAddr,
    input  logic [31:0]          VMEWrData,
    input  logic                 VMEWrMem,
    input  logic                 VMERdMem,
    output logic [31:0]          VMERdData,
    output logic                 VMERdDone,
    output logic                 VMEWrDone,
    output logic                 VMEErr,
    output logic [NCH-1:0]       ch_en_o,
    output logic [NCH*VAL_W-1:0] ch_val_o,
    output logic [NCH-1:0]       ch_pulse_o,
    input  logic [NCH-1:0]       ch_evt_i
);

    localparam logic [31:0] N_WORDS = 32'(2 * NCH);

    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;

    // ---------------- write-in stage ----------------
    if (PIPE_WR != 0) begin : g_wr_pipe
        logic              wr_q;
        logic [ADDR_W-1:0] addr_q;
        logic [31:0]       data_q;

        // Register the incoming write request
        always_ff @(posedge Clk or negedge Rst_n) begin
            if (!Rst_n) begin
                wr_q   <= 1'b0;
                addr_q <= '0;
                data_q <= '0;
            end else begin
                wr_q   <= VMEWrMem;
                addr_q <= VMEAddr;
                data_q <= VMEWrData;
            end
        end

        assign wr_req  = wr_q;
        assign wr_addr = addr_q;
        assign wr_data = data_q;
    end else begin : g_wr_bypass
        assign wr_req  = VMEWrMem;
        assign wr_addr = VMEAddr;
        assign wr_data = VMEWrData;
    end

    logic [31:0] wr_addr32;
    logic        wr_mapped;
    assign wr_addr32 = 32'(wr_addr);
    assign wr_mapped = wr_addr32 < N_WORDS;

    logic [31:0] ctrl_rd [NCH];
    logic [31:0] stat_rd [NCH];

    // ---------------- channel instances ----------------
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic ctrl_wr;
        logic stat_wr;
        assign ctrl_wr = wr_req && wr_mapped && (addr_chan(wr_addr32) == 32'(c))
                         && addr_is_ctrl(wr_addr32);
        assign stat_wr = wr_req && wr_mapped && (addr_chan(wr_addr32) == 32'(c))
                         && !addr_is_ctrl(wr_addr32);

        vme_chan_regs_ch #(
            .VAL_W (VAL_W)
        ) u_ch (
            .clk_i     (Clk),
            .rst_ni    (Rst_n),
            .ctrl_wr_i (ctrl_wr),
            .stat_wr_i (stat_wr),
            .wr_data_i (wr_data),
            .evt_i     (ch_evt_i[c]),
            .en_o      (ch_en_o[c]),
            .val_o     (ch_val_o[c*VAL_W +: VAL_W]),
            .pulse_o   (ch_pulse_o[c]),
            .ctrl_rd_o (ctrl_rd[c]),
            .stat_rd_o (stat_rd[c])
        );
    end

    // ---------------- read decode and mux ----------------
    logic [31:0] rd_addr32;
    logic [31:0] rd_mux;
    logic        rd_err;
    assign rd_addr32 = 32'(VMEAddr);

    // Select the addressed register image; unmapped or idle reads give zero
    always_comb begin
        rd_mux = '0;
        rd_err = VMERdMem && !(rd_addr32 < N_WORDS);
        if (VMERdMem && (rd_addr32 < N_WORDS)) begin
            for (int c = 0; c < NCH; c++) begin
                if (addr_chan(rd_addr32) == 32'(c)) begin
                    rd_mux = addr_is_ctrl(rd_addr32) ? ctrl_rd[c] : stat_rd[c];
                end
            end
        end
    end

    logic        rd_done;
    logic [31:0] rd_data;
    logic        rd_err_out;

    // ---------------- read-out stage ----------------
    if (PIPE_RD != 0) begin : g_rd_pipe
        logic        done_q;
        logic [31:0] data_q;
        logic        err_q;

        // Register the read response
        always_ff @(posedge Clk or negedge Rst_n) begin
            if (!Rst_n) begin
                done_q <= 1'b0;
                data_q <= '0;
                err_q  <= 1'b0;
            end else begin
                done_q <= VMERdMem;
                data_q <= rd_mux;
                err_q  <= rd_err;
            end
        end

        assign rd_done    = done_q;
        assign rd_data    = data_q;
        assign rd_err_out = err_q;
    end else begin : g_rd_bypass
        assign rd_done    = VMERdMem;
        assign rd_data    = rd_mux;
        assign rd_err_out = rd_err;
    end

    assign VMERdDone = rd_done;
    assign VMERdData = rd_data;
    assign VMEWrDone = wr_req;
    assign VMEErr    = (wr_req && !wr_mapped) || rd_err_out;

endmodule
`default_nettype wire

// File: tb/tb_vme_chan_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_vme_chan_regs
// Description : Self-checking bench for vme_chan_regs: a pipelined instance
//               against a behavioural model, plus a zero-latency instance
//               exercised with directed accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vme_chan_regs;

    localparam int NCH   = 4;
    localparam int VAL_W = 10;

    logic        Clk;
    logic        Rst_n;

    // Pipelined instance (PIPE_WR=1, PIPE_RD=1)
    logic [4:0]  VMEAddr;
    logic [31:0] VMEWrData;
    logic        VMEWrMem, VMERdMem;
    logic [31:0] VMERdData;
    logic        VMERdDone, VMEWrDone, VMEErr;
    logic [3:0]  ch_en, ch_pulse, ch_evt;
    logic [39:0] ch_val;

    // Zero-latency instance (PIPE_WR=0, PIPE_RD=0)
    logic [4:0]  addr0;
    logic [31:0] wdata0, rdata0;
    logic        wr0, rd0, rddone0, wrdone0, err0;
    logic [3:0]  en0, pulse0, evt0;
    logic [39:0] val0;

    int n_checks = 0;
    int n_errors = 0;

    vme_chan_regs #(.NCH(NCH), .VAL_W(VAL_W), .PIPE_WR(1), .PIPE_RD(1), .ADDR_W(5)) u_dut (
        .Clk(Clk), .Rst_n(Rst_n), .VMEAddr(VMEAddr), .VMEWrData(VMEWrData),
        .VMEWrMem(VMEWrMem), .VMERdMem(VMERdMem), .VMERdData(VMERdData),
        .VMERdDone(VMERdDone), .VMEWrDone(VMEWrDone), .VMEErr(VMEErr),
        .ch_en_o(ch_en), .ch_val_o(ch_val), .ch_pulse_o(ch_pulse), .ch_evt_i(ch_evt)
    );

    vme_chan_regs #(.NCH(NCH), .VAL_W(VAL_W), .PIPE_WR(0), .PIPE_RD(0), .ADDR_W(5)) u_dut0 (
        .Clk(Clk), .Rst_n(Rst_n), .VMEAddr(addr0), .VMEWrData(wdata0),
        .VMEWrMem(wr0), .VMERdMem(rd0), .VMERdData(rdata0),
        .VMERdDone(rddone0), .VMEWrDone(wrdone0), .VMEErr(err0),
        .ch_en_o(en0), .ch_val_o(val0), .ch_pulse_o(pulse0), .ch_evt_i(evt0)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_en    [NCH];
    bit [9:0]    m_val   [NCH];
    bit          m_pulse [NCH];
    bit          m_flag  [NCH];
    int          m_cnt   [NCH];
    // request waiting in the write stage / response waiting in the read stage
    bit          pw_v;
    int          pw_addr;
    logic [31:0] pw_data;
    bit          pr_v;
    logic [31:0] pr_data;
    bit          pr_err;
    logic [31:0] last_rd;

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_en[c] = 0; m_val[c] = '0; m_pulse[c] = 0; m_flag[c] = 0; m_cnt[c] = 0;
        end
        pw_v = 0; pw_addr = 0; pw_data = '0;
        pr_v = 0; pr_data = '0; pr_err = 0;
    endfunction

    function automatic logic [31:0] model_read(input int a);
        int c;
        if (a >= 2 * NCH) return 32'h0;
        c = a / 2;
        if (a % 2 == 0) return {20'h0, m_val[c], 1'b0, m_en[c]};
        return {16'(m_cnt[c]), 15'h0, m_flag[c]};
    endfunction

    // One bus cycle on the pipelined instance: drive, check at negedge, advance model at posedge
    task automatic step(input bit wr, input bit rd, input int addr,
                        input logic [31:0] data, input logic [3:0] evt);
        logic [31:0] rd_now;
        bit          err_now;
        bit          new_pulse [NCH];
        bit          clr_f     [NCH];
        bit          clr_c     [NCH];
        VMEWrMem  = wr;
        VMERdMem  = rd;
        VMEAddr   = addr[4:0];
        VMEWrData = data;
        ch_evt    = evt;
        rd_now    = model_read(addr);
        err_now   = (addr >= 2 * NCH);
        @(negedge Clk);
        chk("wrdone", 32'(VMEWrDone), 32'(pw_v));
        chk("rddone", 32'(VMERdDone), 32'(pr_v));
        if (pr_v) begin
            chk("rddata", VMERdData, pr_data);
            last_rd = VMERdData;
        end
        chk("err", 32'(VMEErr), 32'((pw_v && pw_addr >= 2 * NCH) || (pr_v && pr_err)));
        for (int c = 0; c < NCH; c++) begin
            chk("en", 32'(ch_en[c]), 32'(m_en[c]));
            chk("val", 32'(ch_val[c*VAL_W +: VAL_W]), 32'(m_val[c]));
            chk("pulse", 32'(ch_pulse[c]), 32'(m_pulse[c]));
        end
        @(posedge Clk);
        for (int c = 0; c < NCH; c++) begin
            new_pulse[c] = 0; clr_f[c] = 0; clr_c[c] = 0;
        end
        if (pw_v && pw_addr < 2 * NCH) begin
            if (pw_addr % 2 == 0) begin
                m_en[pw_addr/2]      = pw_data[0];
                m_val[pw_addr/2]     = pw_data[11:2];
                new_pulse[pw_addr/2] = pw_data[1];
            end else begin
                clr_f[pw_addr/2] = pw_data[0];
                clr_c[pw_addr/2] = pw_data[1];
            end
        end
        for (int c = 0; c < NCH; c++) begin
            m_pulse[c] = new_pulse[c];
            if (clr_c[c]) m_cnt[c] = 0;
            if (evt[c]) m_cnt[c] = (m_cnt[c] + 1 > 65535) ? 65535 : m_cnt[c] + 1;
            m_flag[c] = evt[c] ? 1'b1 : (clr_f[c] ? 1'b0 : m_flag[c]);
        end
        pw_v = wr; pw_addr = addr; pw_data = data;
        pr_v = rd; pr_data = rd_now; pr_err = err_now;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 32'h0, 4'h0);
    endtask

    task automatic check_main_zero(input string tag);
        chk({tag, "_rddata"}, VMERdData, 32'h0);
        chk({tag, "_acks"}, {29'h0, VMERdDone, VMEWrDone, VMEErr}, 32'h0);
        chk({tag, "_en_pulse"}, {24'h0, ch_en, ch_pulse}, 32'h0);
        chk({tag, "_val_lo"}, ch_val[31:0], 32'h0);
        chk({tag, "_val_hi"}, 32'(ch_val[39:32]), 32'h0);
    endtask

    initial begin
        Rst_n = 1'b0;
        VMEWrMem = 0; VMERdMem = 0; VMEAddr = '0; VMEWrData = '0; ch_evt = '0;
        wr0 = 0; rd0 = 0; addr0 = '0; wdata0 = '0; evt0 = '0;
        last_rd = '0;
        model_reset();
        repeat (3) @(negedge Clk);
        check_main_zero("rst");
        chk("rst0_outs", {rdata0[27:0], rddone0, wrdone0, err0, 1'b0} | 32'(en0) | 32'(pulse0), 32'h0);
        chk("rst0_val", val0[31:0], 32'h0);
        Rst_n = 1'b1;
        @(posedge Clk); #1;

        // ---- zero-latency instance: same-cycle acks, simultaneous access ----
        wr0 = 1; rd0 = 1; addr0 = 5'd0; wdata0 = 32'h5;
        @(negedge Clk);
        chk("p0_wrdone", 32'(wrdone0), 32'h1);
        chk("p0_rddone", 32'(rddone0), 32'h1);
        chk("p0_rd_old", rdata0, 32'h0);
        chk("p0_err", 32'(err0), 32'h0);
        @(posedge Clk); #1;
        wr0 = 0; rd0 = 1; addr0 = 5'd0;
        @(negedge Clk);
        chk("p0_rd_new", rdata0, 32'h5);
        chk("p0_en", 32'(en0), 32'h1);
        chk("p0_val", val0[31:0], 32'h1);
        @(posedge Clk); #1;
        wr0 = 1; rd0 = 1; addr0 = 5'd9; wdata0 = 32'hFFFF_FFFF;
        @(negedge Clk);
        chk("p0_unm_acks", {30'h0, rddone0, wrdone0}, 32'h3);
        chk("p0_unm_err", 32'(err0), 32'h1);
        chk("p0_unm_data", rdata0, 32'h0);
        @(posedge Clk); #1;
        wr0 = 1; rd0 = 0; addr0 = 5'd2; wdata0 = 32'h2;
        @(negedge Clk);
        chk("p0_unm_noeff", {24'h0, en0, pulse0}, 32'h10);
        chk("p0_unm_val", val0[31:0], 32'h1);
        @(posedge Clk); #1;
        wr0 = 0;
        @(negedge Clk);
        chk("p0_pulse", 32'(pulse0), 32'h2);
        @(posedge Clk); #1;
        @(negedge Clk);
        chk("p0_pulse_end", 32'(pulse0), 32'h0);
        @(posedge Clk); #1;

        // ---- pipelined instance: CTRL write / read-back ----
        step(1, 0, 4, 32'h0000_0FFF, 4'h0);
        idle(3);
        step(0, 1, 4, 32'h0, 4'h0);
        idle(1);
        chk("ctrl_rb", last_rd, 32'h0000_0FFD);

        // ---- reset in the middle of a write ----
        step(1, 0, 0, 32'h0000_0FFF, 4'h0);
        VMEWrMem = 0;
        #2 Rst_n = 1'b0;
        #1 check_main_zero("rst_mid");
        @(negedge Clk);
        Rst_n = 1'b1;
        model_reset();
        @(posedge Clk); #1;
        idle(2);
        step(0, 1, 0, 32'h0, 4'h0);
        idle(1);
        chk("rst_ctrl0", last_rd, 32'h0);

        // ---- events, flag and counter clear ----
        for (int i = 0; i < 3; i++) step(0, 0, 0, 32'h0, 4'b0010);
        step(0, 1, 3, 32'h0, 4'h0);
        idle(1);
        chk("stat_evt", last_rd, 32'h0003_0001);
        step(1, 0, 3, 32'h3, 4'b0010);
        step(0, 0, 0, 32'h0, 4'b0010);
        step(0, 1, 3, 32'h0, 4'h0);
        idle(1);
        chk("stat_clr_evt", last_rd, 32'h0001_0001);

        // ---- unmapped address ----
        step(0, 1, 9, 32'h0, 4'h0);
        idle(1);
        chk("unm_rd", last_rd, 32'h0);
        step(1, 0, 9, 32'hFFFF_FFFF, 4'h0);
        idle(2);

        // ---- counter saturation ----
        for (int i = 0; i < 70000; i++) step(0, 0, 0, 32'h0, 4'b0001);
        step(0, 1, 1, 32'h0, 4'h0);
        idle(1);
        chk("sat", 32'(last_rd[31:16]), 32'h0000_FFFF);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 32'h0, 4'b0001);
        step(0, 1, 1, 32'h0, 4'h0);
        idle(1);
        chk("sat_hold", 32'(last_rd[31:16]), 32'h0000_FFFF);

        // ---- randomized traffic against the model ----
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 3) == 0, ($urandom % 3) == 0, int'($urandom % 12),
                 $urandom, 4'($urandom & $urandom));
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vme_chan_regs.md
Name: vme_chan_regs

Overview:
- Parametrised multi-channel control/status register bank on the VME-style memory bus (VMERdMem/VMEWrMem strobes, VMERdDone/VMEWrDone acks).
- Replicates a per-channel control register (enable, pulse, value field) NCH times and adds a per-channel status register with a sticky event flag and a saturating event counter.
- Adds an address decoder with error response, plus selectable write-in and read-out pipelining.
- Sits between the VME slave core and per-channel datapath logic.

Parameters:
- NCH, 4, number of channels (1..16).
- VAL_W, 10, width of the control value field (1..24).
- PIPE_WR, 1, write-path input register stages (0 or 1).
- PIPE_RD, 1, read-path output register stages (0 or 1).
- ADDR_W, 5, word-address width; must satisfy 2**ADDR_W >= 2*NCH.

Ports:
- Clk  in  1  clock.
- Rst_n  in  1  asynchronous active-low reset.
- VMEAddr  in  ADDR_W  word address, valid while a strobe is high.
- VMEWrData  in  32  write data.
- VMEWrMem  in  1  write strobe, one cycle per access.
- VMERdMem  in  1  read strobe, one cycle per access.
- VMERdData  out  32  read data, valid with VMERdDone.
- VMERdDone  out  1  read ack, one-cycle pulse.
- VMEWrDone  out  1  write ack, one-cycle pulse.
- VMEErr  out  1  pulses with the ack of an access to an unmapped address.
- ch_en_o  out  NCH  per-channel enable.
- ch_val_o  out  NCH*VAL_W  per-channel value; channel c occupies [c*VAL_W +: VAL_W].
- ch_pulse_o  out  NCH  one-cycle pulse per channel.
- ch_evt_i  in  NCH  per-channel event inputs, synchronous to Clk, level-sampled every cycle.

Behaviour:
- Reset: Rst_n low asynchronously clears every register and output.
  - All outputs read 0, including VMERdData, all acks, VMEErr, ch_en_o, ch_val_o, ch_pulse_o, all flags and all counters.
  - A transaction in flight when reset asserts is dropped; no ack is issued after reset releases.
- Address map (word addresses):
  - Address 2c = CTRL of channel c.
  - Address 2c+1 = STAT of channel c.
  - Addresses >= 2*NCH are unmapped.
- CTRL layout:
  - Bit 0: en, read/write.
  - Bit 1: pulse, write-only, reads 0.
  - Bits [VAL_W+1:2]: val, read/write.
  - Remaining bits: read 0, writes ignored.
- STAT layout:
  - Bit 0: evt flag, sticky; writing 1 clears it, writing 0 has no effect.
  - Bit 1: write 1 clears the counter; reads 0.
  - Bits [31:16]: event counter.
  - Other bits read 0.
- Event counter:
  - Increments by 1 on each cycle ch_evt_i[c]=1.
  - Saturates at 0xFFFF and does not wrap.
- Simultaneous event and clear in the same cycle:
  - Flag: set wins, flag ends at 1.
  - Counter: clear is applied first, then the increment, so the counter ends at 1.
- Write path:
  - VMEWrMem, VMEAddr and VMEWrData pass through PIPE_WR register stages.
  - The decoded write request updates the target register on the next edge.
  - VMEWrDone is combinational from the (possibly delayed) request, so it appears PIPE_WR cycles after VMEWrMem.
  - ch_pulse_o[c] is high for exactly the one cycle after the register update edge; it is not sticky.
- Read path:
  - Decode and mux are combinational on VMEAddr and VMERdMem, then pass through PIPE_RD output register stages.
  - VMERdDone and VMERdData therefore appear PIPE_RD cycles after VMERdMem.
  - Reads have no side effects; the flag and counter are unchanged by a read.
- Unmapped address:
  - The access is acked with normal latency and VMEErr is asserted with the ack.
  - Read data is 0; a write changes nothing.
- VMERdMem and VMEWrMem in the same cycle:
  - Both are serviced at the same VMEAddr.
  - The read returns the pre-write value.
  - VMEErr is asserted if the address is unmapped.
- Back-to-back strobes on consecutive cycles are accepted; there is no wait state and no busy state.
- Read-data bits that are not driven by a field read 0, never X.

Decomposition:
- Package vme_chan_regs_pkg holds:
  - Field offsets: EN_BIT=0, PULSE_BIT=1, VAL_LSB=2, EVT_BIT=0, CNTCLR_BIT=1, CNT_LSB=16.
  - CNT_MAX=16'hFFFF.
  - Function addr_is_ctrl/addr_chan for decoding.
- One natural sub-module: vme_chan_regs_ch, which holds one channel's CTRL/STAT registers, flag, counter and pulse.
  - It is instantiated NCH times in a generate loop.
  - The top level holds the pipelining, decode and read mux.

Test Plan:
- Reset:
  - Stimulus: hold Rst_n low mid-write, then release.
  - Response: all outputs 0, no VMEWrDone after release, reading CTRL ch0 returns 0x00000000.
- CTRL write/readback (NCH=4, VAL_W=10, PIPE=1/1):
  - Stimulus: write 0x00000FFF to address 4 (ch2 CTRL).
  - Response: VMEWrDone 1 cycle after the strobe; ch_en_o[2]=1; ch_val_o[29:20]=0x3FF; ch_pulse_o[2] high for exactly 1 cycle.
  - Stimulus: read address 4.
  - Response: 0x00000FFD, with VMERdDone 1 cycle after the strobe.
- Events:
  - Stimulus: ch_evt_i[1] high for 3 cycles.
  - Response: STAT of ch1 (address 3) reads 0x00030001.
  - Stimulus: write 0x3 to address 3 while ch_evt_i[1]=1.
  - Response: STAT reads 0x00010001.
- Saturation:
  - Stimulus: ch_evt_i[0] high for 70000 cycles.
  - Response: counter field reads 0xFFFF and stays 0xFFFF.
- Unmapped address:
  - Stimulus: read address 9.
  - Response: VMERdDone with VMEErr=1 and data 0.
  - Stimulus: write to address 9.
  - Response: VMEWrDone with VMEErr=1 and no register change.
- Pipeline variants and simultaneous access (PIPE_WR=0, PIPE_RD=0):
  - Stimulus: single write or single read.
  - Response: ack in the same cycle as the strobe.
  - Stimulus: VMERdMem and VMEWrMem together on address 0 with data 0x5.
  - Response: the read returns the old value and the write then takes effect.
